// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one synchronous single-port memory between the
// core and a DMA/program-loader port. Round-robin between the two, with a
// bounded DMA burst lock, and read data steered back to whoever issued it.
//
// Optional feature: define ARB_STATS_EN to build the saturating core stall
// counter on core_wait_cnt; without it core_wait_cnt is tied to zero.
//
// Handshake: a requester raises req with we/addr/wdata and holds them
// stable until it sees gnt in the same cycle; gnt is combinational and the
// access happens in that cycle. Read data comes back one cycle later with
// rvalid on the owning port only.
module mem_port_arbiter #(
    parameter int ADDR_W    = 16,
    parameter int DATA_W    = 16,
    parameter int MAX_BURST = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              core_req,
    input  logic              core_we,
    input  logic [ADDR_W-1:0] core_addr,
    input  logic [DATA_W-1:0] core_wdata,
    output logic              core_gnt,
    output logic              core_stall,
    output logic              core_rvalid,
    output logic [DATA_W-1:0] core_rdata,
    input  logic              dma_req,
    input  logic              dma_we,
    input  logic [ADDR_W-1:0] dma_addr,
    input  logic [DATA_W-1:0] dma_wdata,
    input  logic              dma_lock,
    output logic              dma_gnt,
    output logic              dma_rvalid,
    output logic [DATA_W-1:0] dma_rdata,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic [15:0]       core_wait_cnt,
    output logic [1:0]        state_dbg
);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        CORE      = 2'd1,
        DMA_BURST = 2'd2
    } state_t;

    localparam int               CNT_W    = $clog2(MAX_BURST + 1);
    localparam logic [CNT_W-1:0] MAX_CNT  = CNT_W'(MAX_BURST);
    localparam logic             OWN_CORE = 1'b0;
    localparam logic             OWN_DMA  = 1'b1;

    state_t           state, state_nxt;
    logic             last, last_nxt;
    logic [CNT_W-1:0] burst_cnt, cnt_nxt;
    logic             rd_pend, rd_owner;
    logic             grant_core, grant_dma;

    // Arbitration: grant decision, next state and burst counter update.
    always_comb begin
        grant_core = 1'b0;
        grant_dma  = 1'b0;
        state_nxt  = IDLE;
        cnt_nxt    = burst_cnt;
        if (rst) begin
            cnt_nxt = '0;
        end else if (state == DMA_BURST && dma_req && dma_lock) begin
            if (core_req && burst_cnt == MAX_CNT) begin
                // Burst budget spent while the core waits: core goes next.
                grant_core = 1'b1;
                cnt_nxt    = '0;
                state_nxt  = CORE;
            end else begin
                // The budget only drains while the core is actually waiting.
                grant_dma = 1'b1;
                state_nxt = DMA_BURST;
                if (core_req) cnt_nxt = burst_cnt + CNT_W'(1);
            end
        end else begin
            // Plain round-robin; any burst in progress is over.
            cnt_nxt = '0;
            if (core_req && (!dma_req || last == OWN_DMA)) grant_core = 1'b1;
            else if (dma_req)                                grant_dma  = 1'b1;
            if (grant_core) begin
                state_nxt = CORE;
            end else if (grant_dma && dma_lock) begin
                state_nxt = DMA_BURST;
                if (core_req) cnt_nxt = CNT_W'(1);
            end
        end
    end

    // Remember the winner for round-robin; hold it on idle cycles.
    always_comb begin
        last_nxt = last;
        if (grant_core)     last_nxt = OWN_CORE;
        else if (grant_dma) last_nxt = OWN_DMA;
    end

    // Steer the winner onto the memory port; zeros when nobody is granted.
    always_comb begin
        mem_en    = grant_core | grant_dma;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        if (grant_core) begin
            mem_we    = core_we;
            mem_addr  = core_addr;
            mem_wdata = core_wdata;
        end else if (grant_dma) begin
            mem_we    = dma_we;
            mem_addr  = dma_addr;
            mem_wdata = dma_wdata;
        end
    end

    assign core_gnt   = grant_core;
    assign dma_gnt    = grant_dma;
    assign core_stall = core_req & ~grant_core;
    assign state_dbg  = state;

    // Read return: rst gates rvalid so a read in flight at reset is dropped.
    assign core_rvalid = rd_pend & (rd_owner == OWN_CORE) & ~rst;
    assign dma_rvalid  = rd_pend & (rd_owner == OWN_DMA) & ~rst;
    assign core_rdata  = core_rvalid ? mem_rdata : '0;
    assign dma_rdata   = dma_rvalid ? mem_rdata : '0;

    // State, round-robin pointer, burst count and read-return tag.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            last      <= OWN_DMA;
            burst_cnt <= '0;
            rd_pend   <= 1'b0;
            rd_owner  <= OWN_CORE;
        end else begin
            state     <= state_nxt;
            last      <= last_nxt;
            burst_cnt <= cnt_nxt;
            rd_pend   <= (grant_core & ~core_we) | (grant_dma & ~dma_we);
            rd_owner  <= grant_dma ? OWN_DMA : OWN_CORE;
        end
    end

`ifdef ARB_STATS_EN
    logic [15:0] wait_cnt;

    // Saturating count of cycles the core spent stalled.
    always_ff @(posedge clk) begin
        if (rst) begin
            wait_cnt <= 16'h0;
        end else if (core_stall && wait_cnt != 16'hFFFF) begin
            wait_cnt <= wait_cnt + 16'd1;
        end
    end

    assign core_wait_cnt = wait_cnt;
`else
    assign core_wait_cnt = 16'h0;
`endif

endmodule
